ysyx_23060077_axi_sram_slave: RTL and testbench
===============================================

// Module: ysyx_23060077_axi_sram_slave
// PURPOSE
//  AXI4 responder (slave) backed by an on-chip word-addressed SRAM array; the far end of the
//  CPU-side AXI master bridge. Serves independent read and write channels with INCR/FIXED bursts,
//  byte strobes and a programmable read latency. Used as the sim/SoC memory target for ifu/lsu traffic.
// PARAMETERS
//  ADDR_WIDTH  32            AXI address width
//  DATA_WIDTH  64            AXI data width; STRB_WIDTH = DATA_WIDTH/8
//  ID_WIDTH    4             AXI ID width; IDs echoed on B/R
//  MEM_DEPTH   4096          SRAM words of DATA_WIDTH bits (power of 2)
//  BASE_ADDR   32'h8000_0000 first byte address served
//  RD_LATENCY  1             cycles from AR handshake to first r_valid (>=1)
// PORTS
//  aclk            in  1    clock
//  areset_n        in  1    synchronous reset, ACTIVE-HIGH despite name (reset when 1)
//  axi_aw_valid_i/axi_aw_ready_o  in/out 1; axi_aw_addr_i in ADDR_WIDTH; axi_aw_id_i in ID_WIDTH
//  axi_aw_len_i in 8; axi_aw_size_i in 3; axi_aw_burst_i in 2
//  axi_w_valid_i/axi_w_ready_o in/out 1; axi_w_data_i in DATA_WIDTH; axi_w_strb_i in STRB_WIDTH; axi_w_last_i in 1
//  axi_b_valid_o/axi_b_ready_i out/in 1; axi_b_resp_o out 2; axi_b_id_o out ID_WIDTH
//  axi_ar_valid_i/axi_ar_ready_o in/out 1; axi_ar_addr_i in ADDR_WIDTH; axi_ar_id_i in ID_WIDTH
//  axi_ar_len_i in 8; axi_ar_size_i in 3; axi_ar_burst_i in 2
//  axi_r_valid_o/axi_r_ready_i out/in 1; axi_r_data_o out DATA_WIDTH; axi_r_resp_o out 2
//  axi_r_last_o out 1; axi_r_id_o out ID_WIDTH
// BEHAVIOUR
//  Reset: both FSMs -> IDLE; all valid/ready/last outputs 0, resp/id/data 0, counters 0. Mid-burst
//   reset abandons the transaction; SRAM contents retained (not cleared).
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: aw_ready=1. On aw handshake latch addr/id/len/size/burst, beat cnt=0.
//    w_ready=1 in W_IDLE only while aw_valid=1: first W beat may be accepted in the SAME cycle as AW
//    (master drives aw_valid and w_valid together). If so and len==0 -> W_RESP, else cnt=1, -> W_DATA.
//   W_DATA: w_ready=1; per beat write mem[word] with strb byte-enables, cnt++, addr advance;
//    beat with cnt==len -> W_RESP. w_last ignored for control; w_last!=(cnt==len) sets sticky SLVERR.
//   W_RESP: b_valid=1, b_id=latched id, b_resp; hold until b_ready -> W_IDLE (b may complete cycle after last beat).
//  Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE:
//   R_IDLE: ar_ready=1; on handshake latch fields, lat cnt=RD_LATENCY-1, -> R_WAIT (or R_DATA if RD_LATENCY==1).
//   R_WAIT: decrement; at 0 -> R_DATA. R_DATA: r_valid=1, r_data=mem[word] full word (no lane shift;
//    master extracts bytes), r_id=latched id, r_last=(cnt==len); data/last stable while r_valid&!r_ready;
//    on r_ready cnt++/addr advance; handshake with r_last -> R_IDLE.
//  Address: word = (addr-BASE_ADDR)>>log2(STRB_WIDTH). INCR: addr += 1<<size per beat (32-bit wrap).
//   FIXED (2'b00): addr constant. WRAP (2'b10): treated as INCR. Reserved 2'b11: SLVERR, no writes.
//  Out of range (addr<BASE_ADDR or word>=MEM_DEPTH): write beat dropped, resp SLVERR(2'b10);
//   read beat r_data=0, r_resp=SLVERR for that beat. Otherwise OKAY(2'b00).
//  Simultaneous read and write same word same cycle: read returns pre-write value. Channels fully concurrent.
//  Throughput: 1 beat/cycle on R and W when counterpart holds valid/ready high.
// STRUCTURE
//  Shared header (ysyx_23060077_axi_define.v): AXI_RESP_OKAY/SLVERR, AXI_BURST_FIXED/INCR/WRAP,
//   AXI_SIZE_*, width macros, state-width macros for the two FSMs.
//  One sub-module: ysyx_23060077_sram_2p (1 write port w/ byte enables, 1 async-read port, MEM_DEPTH x DATA_WIDTH).
//  Burst address generator is a shared function in this file used by both FSMs.
// TESTING
//  1 Single write aw+w same cycle addr 0x8000_0008 data 0x1122334455667788 strb 0xFF len 0 -> B OKAY next cycle;
//    read same addr len 0 -> r_data 0x1122334455667788, r_last=1, after RD_LATENCY cycles.
//  2 Byte write addr 0x8000_0003 strb 0x08 data 0xAB<<24 over 0 word -> read word 0x00000000AB000000.
//  3 INCR burst len 3 size 3 at 0x8000_0100, data 1..4, r_ready toggling 1,0,1 -> 4 beats 1..4 in order,
//    last only on beat 4, data held through stalls.
//  4 Address 0x7FFF_FFF8 and 0x8000_0000+MEM_DEPTH*8 -> b_resp/r_resp SLVERR, r_data 0, SRAM unchanged.
//  5 Concurrent write burst and read burst to same word; b_ready low 5 cycles -> b_valid held, ids echoed.
//  6 Assert areset_n mid read burst (beat 2 of 4) -> r_valid 0 next cycle, ar_ready 1, data intact.

Source files
------------

// File: rtl/ysyx_23060077_axi_sram_slave_pkg.sv
// Shared AXI constants and FSM state types for the SRAM-backed AXI responder.
// No logic: constants and types only.
// No flow control of its own; the importers apply backpressure.
package ysyx_23060077_axi_sram_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  // Width of the read-latency down-counter; RD_LATENCY must fit in it.
  localparam int LAT_W = 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

endpackage

// File: rtl/ysyx_23060077_sram_2p.sv
// Word-organised SRAM: one byte-enabled synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge; read is combinational and returns the pre-write word.
// No backpressure; the caller qualifies we_i. Contents are not reset.
module ysyx_23060077_sram_2p #(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 64,
  parameter int AW         = $clog2(DEPTH),
  parameter int BE_W       = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_23060077_axi_sram_slave.sv
// AXI4 responder over an on-chip SRAM with independent read and write FSMs, INCR/FIXED bursts.
// Latency: first W beat may ride with AW, B follows the last beat by one cycle; R after RD_LATENCY.
// Backpressure: B and R outputs (and R data) hold steady until b_ready / r_ready.
module ysyx_23060077_axi_sram_slave
  import ysyx_23060077_axi_sram_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_DEPTH  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
  parameter int                    RD_LATENCY = 1,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  axi_aw_valid_i,
  output logic                  axi_aw_ready_o,
  input  logic [ADDR_WIDTH-1:0] axi_aw_addr_i,
  input  logic [ID_WIDTH-1:0]   axi_aw_id_i,
  input  logic [7:0]            axi_aw_len_i,
  input  logic [2:0]            axi_aw_size_i,
  input  logic [1:0]            axi_aw_burst_i,
  input  logic                  axi_w_valid_i,
  output logic                  axi_w_ready_o,
  input  logic [DATA_WIDTH-1:0] axi_w_data_i,
  input  logic [STRB_WIDTH-1:0] axi_w_strb_i,
  input  logic                  axi_w_last_i,
  output logic                  axi_b_valid_o,
  input  logic                  axi_b_ready_i,
  output logic [1:0]            axi_b_resp_o,
  output logic [ID_WIDTH-1:0]   axi_b_id_o,
  input  logic                  axi_ar_valid_i,
  output logic                  axi_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] axi_ar_addr_i,
  input  logic [ID_WIDTH-1:0]   axi_ar_id_i,
  input  logic [7:0]            axi_ar_len_i,
  input  logic [2:0]            axi_ar_size_i,
  input  logic [1:0]            axi_ar_burst_i,
  output logic                  axi_r_valid_o,
  input  logic                  axi_r_ready_i,
  output logic [DATA_WIDTH-1:0] axi_r_data_o,
  output logic [1:0]            axi_r_resp_o,
  output logic                  axi_r_last_o,
  output logic [ID_WIDTH-1:0]   axi_r_id_o
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int WORD_AW  = $clog2(MEM_DEPTH);

  // Next beat address: FIXED holds, everything else (WRAP included) increments with 32-bit wrap.
  function automatic logic [ADDR_WIDTH-1:0] burst_next(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
    if (burst == AXI_BURST_FIXED) return a;
    return a + (ADDR_WIDTH'(1) << size);
  endfunction

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> ADDR_LSB) >= ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [WORD_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return WORD_AW'((a - BASE_ADDR) >> ADDR_LSB);
  endfunction

  // The reset pin is active-high; every handshake output is gated by it.
  logic live;
  assign live = ~areset_n;

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;

  // In W_IDLE the beat riding with AW uses the AW fields directly.
  logic                  w_from_aw;
  logic [ADDR_WIDTH-1:0] wc_addr;
  logic [7:0]            wc_len, wc_cnt;
  logic [2:0]            wc_size;
  logic [1:0]            wc_burst;
  logic                  wc_err, wc_last, wc_mis, mem_we;

  assign w_from_aw = (w_state_q == W_IDLE);
  assign wc_addr   = w_from_aw ? axi_aw_addr_i  : w_addr_q;
  assign wc_len    = w_from_aw ? axi_aw_len_i   : w_len_q;
  assign wc_size   = w_from_aw ? axi_aw_size_i  : w_size_q;
  assign wc_burst  = w_from_aw ? axi_aw_burst_i : w_burst_q;
  assign wc_cnt    = w_from_aw ? 8'd0           : w_cnt_q;
  assign wc_err    = addr_bad(wc_addr) || (wc_burst == AXI_BURST_RSVD);
  assign wc_last   = (wc_cnt == wc_len);
  assign wc_mis    = (axi_w_last_i != wc_last);

  // Write FSM next state, SRAM write strobe and AW/W/B handshake outputs.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    mem_we         = 1'b0;
    axi_aw_ready_o = 1'b0;
    axi_w_ready_o  = 1'b0;
    axi_b_valid_o  = 1'b0;
    axi_b_resp_o   = AXI_RESP_OKAY;
    axi_b_id_o     = '0;
    case (w_state_q)
      W_IDLE: begin
        axi_aw_ready_o = live;
        axi_w_ready_o  = live & axi_aw_valid_i;
        if (live && axi_aw_valid_i) begin
          w_id_d    = axi_aw_id_i;
          w_len_d   = axi_aw_len_i;
          w_size_d  = axi_aw_size_i;
          w_burst_d = axi_aw_burst_i;
          if (axi_w_valid_i) begin
            mem_we    = ~wc_err;
            w_addr_d  = burst_next(wc_addr, wc_size, wc_burst);
            w_cnt_d   = 8'd1;
            w_err_d   = wc_err | wc_mis;
            w_state_d = wc_last ? W_RESP : W_DATA;
          end else begin
            w_addr_d  = axi_aw_addr_i;
            w_cnt_d   = 8'd0;
            w_err_d   = 1'b0;
            w_state_d = W_DATA;
          end
        end
      end
      W_DATA: begin
        axi_w_ready_o = live;
        if (live && axi_w_valid_i) begin
          mem_we   = ~wc_err;
          w_addr_d = burst_next(wc_addr, wc_size, wc_burst);
          w_cnt_d  = w_cnt_q + 8'd1;
          w_err_d  = w_err_q | wc_err | wc_mis;
          if (wc_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (live) begin
          axi_b_valid_o = 1'b1;
          axi_b_resp_o  = w_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          axi_b_id_o    = w_id_q;
          if (axi_b_ready_i) w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM state and latched burst fields.
  always_ff @(posedge aclk) begin
    if (areset_n) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [LAT_W-1:0]      r_lat_q, r_lat_d;
  // A stalled beat is frozen here so a concurrent write cannot change it under the master.
  logic [DATA_WIDTH-1:0] r_hold_q, r_hold_d;
  logic                  r_hold_vld_q, r_hold_vld_d;

  logic [DATA_WIDTH-1:0] sram_rdata, r_beat_data;
  logic                  r_err, r_last;

  assign r_err       = addr_bad(r_addr_q) || (r_burst_q == AXI_BURST_RSVD);
  assign r_last      = (r_cnt_q == r_len_q);
  assign r_beat_data = r_err ? '0 : (r_hold_vld_q ? r_hold_q : sram_rdata);

  // Read FSM next state, latency countdown and AR/R handshake outputs.
  always_comb begin
    r_state_d    = r_state_q;
    r_addr_d     = r_addr_q;
    r_id_d       = r_id_q;
    r_len_d      = r_len_q;
    r_size_d     = r_size_q;
    r_burst_d    = r_burst_q;
    r_cnt_d      = r_cnt_q;
    r_lat_d      = r_lat_q;
    r_hold_d     = r_hold_q;
    r_hold_vld_d = r_hold_vld_q;
    axi_ar_ready_o = 1'b0;
    axi_r_valid_o  = 1'b0;
    axi_r_data_o   = '0;
    axi_r_resp_o   = AXI_RESP_OKAY;
    axi_r_last_o   = 1'b0;
    axi_r_id_o     = '0;
    case (r_state_q)
      R_IDLE: begin
        axi_ar_ready_o = live;
        if (live && axi_ar_valid_i) begin
          r_addr_d     = axi_ar_addr_i;
          r_id_d       = axi_ar_id_i;
          r_len_d      = axi_ar_len_i;
          r_size_d     = axi_ar_size_i;
          r_burst_d    = axi_ar_burst_i;
          r_cnt_d      = 8'd0;
          r_lat_d      = LAT_W'(RD_LATENCY - 1);
          r_hold_vld_d = 1'b0;
          r_state_d    = (RD_LATENCY == 1) ? R_DATA : R_WAIT;
        end
      end
      R_WAIT: begin
        if (live) begin
          r_lat_d = r_lat_q - LAT_W'(1);
          if (r_lat_q == LAT_W'(1)) r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (live) begin
          axi_r_valid_o = 1'b1;
          axi_r_data_o  = r_beat_data;
          axi_r_resp_o  = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          axi_r_last_o  = r_last;
          axi_r_id_o    = r_id_q;
          if (axi_r_ready_i) begin
            r_hold_vld_d = 1'b0;
            if (r_last) begin
              r_state_d = R_IDLE;
            end else begin
              r_cnt_d  = r_cnt_q + 8'd1;
              r_addr_d = burst_next(r_addr_q, r_size_q, r_burst_q);
            end
          end else begin
            r_hold_vld_d = 1'b1;
            r_hold_d     = r_beat_data;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM state, latched burst fields and stall hold register.
  always_ff @(posedge aclk) begin
    if (areset_n) begin
      r_state_q    <= R_IDLE;
      r_addr_q     <= '0;
      r_id_q       <= '0;
      r_len_q      <= '0;
      r_size_q     <= '0;
      r_burst_q    <= '0;
      r_cnt_q      <= '0;
      r_lat_q      <= '0;
      r_hold_q     <= '0;
      r_hold_vld_q <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      r_addr_q     <= r_addr_d;
      r_id_q       <= r_id_d;
      r_len_q      <= r_len_d;
      r_size_q     <= r_size_d;
      r_burst_q    <= r_burst_d;
      r_cnt_q      <= r_cnt_d;
      r_lat_q      <= r_lat_d;
      r_hold_q     <= r_hold_d;
      r_hold_vld_q <= r_hold_vld_d;
    end
  end

  logic [WORD_AW-1:0] mem_waddr, mem_raddr;
  assign mem_waddr = word_idx(wc_addr);
  assign mem_raddr = word_idx(r_addr_q);

  ysyx_23060077_sram_2p #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sram (
    .clk_i   (aclk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (axi_w_data_i),
    .be_i    (axi_w_strb_i),
    .raddr_i (mem_raddr),
    .rdata_o (sram_rdata)
  );

endmodule

// File: tb/tb_ysyx_23060077_axi_sram_slave.sv
// Directed bench for the AXI SRAM responder.
// Drives inputs 1 time unit after the rising edge, samples outputs on the falling edge.
// Exercises single/byte/burst writes, stalled reads, out-of-range, concurrency and mid-burst reset.
module tb_ysyx_23060077_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        axi_aw_valid_i, axi_aw_ready_o;
  logic [31:0] axi_aw_addr_i;
  logic [3:0]  axi_aw_id_i;
  logic [7:0]  axi_aw_len_i;
  logic [2:0]  axi_aw_size_i;
  logic [1:0]  axi_aw_burst_i;
  logic        axi_w_valid_i, axi_w_ready_o;
  logic [63:0] axi_w_data_i;
  logic [7:0]  axi_w_strb_i;
  logic        axi_w_last_i;
  logic        axi_b_valid_o, axi_b_ready_i;
  logic [1:0]  axi_b_resp_o;
  logic [3:0]  axi_b_id_o;
  logic        axi_ar_valid_i, axi_ar_ready_o;
  logic [31:0] axi_ar_addr_i;
  logic [3:0]  axi_ar_id_i;
  logic [7:0]  axi_ar_len_i;
  logic [2:0]  axi_ar_size_i;
  logic [1:0]  axi_ar_burst_i;
  logic        axi_r_valid_o, axi_r_ready_i;
  logic [63:0] axi_r_data_o;
  logic [1:0]  axi_r_resp_o;
  logic        axi_r_last_o;
  logic [3:0]  axi_r_id_o;

  always #5 aclk = ~aclk;

  ysyx_23060077_axi_sram_slave dut (
    .aclk(aclk), .areset_n(areset_n),
    .axi_aw_valid_i(axi_aw_valid_i), .axi_aw_ready_o(axi_aw_ready_o), .axi_aw_addr_i(axi_aw_addr_i),
    .axi_aw_id_i(axi_aw_id_i), .axi_aw_len_i(axi_aw_len_i), .axi_aw_size_i(axi_aw_size_i),
    .axi_aw_burst_i(axi_aw_burst_i),
    .axi_w_valid_i(axi_w_valid_i), .axi_w_ready_o(axi_w_ready_o), .axi_w_data_i(axi_w_data_i),
    .axi_w_strb_i(axi_w_strb_i), .axi_w_last_i(axi_w_last_i),
    .axi_b_valid_o(axi_b_valid_o), .axi_b_ready_i(axi_b_ready_i), .axi_b_resp_o(axi_b_resp_o),
    .axi_b_id_o(axi_b_id_o),
    .axi_ar_valid_i(axi_ar_valid_i), .axi_ar_ready_o(axi_ar_ready_o), .axi_ar_addr_i(axi_ar_addr_i),
    .axi_ar_id_i(axi_ar_id_i), .axi_ar_len_i(axi_ar_len_i), .axi_ar_size_i(axi_ar_size_i),
    .axi_ar_burst_i(axi_ar_burst_i),
    .axi_r_valid_o(axi_r_valid_o), .axi_r_ready_i(axi_r_ready_i), .axi_r_data_o(axi_r_data_o),
    .axi_r_resp_o(axi_r_resp_o), .axi_r_last_o(axi_r_last_o), .axi_r_id_o(axi_r_id_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  rid_got, bid_got;
  logic [1:0]  bresp_got;
  int          rlat, bwait;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // AW with the first W beat in the same cycle, remaining beats back to back, then collect B.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
    int  beat, cyc;
    bit  aw_hs, w_hs, got;
    axi_aw_valid_i = 1'b1; axi_aw_addr_i = addr; axi_aw_len_i = len;
    axi_aw_size_i = size; axi_aw_burst_i = burst; axi_aw_id_i = id;
    axi_w_valid_i = 1'b1; axi_w_data_i = wd[0]; axi_w_strb_i = ws[0]; axi_w_last_i = (len == 8'd0);
    beat = 0; cyc = 0;
    while ((axi_aw_valid_i || axi_w_valid_i) && cyc < 64) begin
      @(negedge aclk);
      aw_hs = axi_aw_valid_i && axi_aw_ready_o;
      w_hs  = axi_w_valid_i && axi_w_ready_o;
      @(posedge aclk); #1;
      cyc++;
      if (aw_hs) axi_aw_valid_i = 1'b0;
      if (w_hs) begin
        beat++;
        if (beat > int'(len)) axi_w_valid_i = 1'b0;
        else begin
          axi_w_data_i = wd[beat]; axi_w_strb_i = ws[beat]; axi_w_last_i = (beat == int'(len));
        end
      end
    end
    chk("wr_handshake_done", 64'(cyc < 64), 64'd1);
    axi_aw_valid_i = 1'b0; axi_w_valid_i = 1'b0;
    axi_b_ready_i = 1'b1; got = 1'b0; bwait = 0;
    while (!got && bwait < 64) begin
      @(negedge aclk);
      bwait++;
      if (axi_b_valid_o) begin got = 1'b1; bresp_got = axi_b_resp_o; bid_got = axi_b_id_o; end
      @(posedge aclk); #1;
    end
    axi_b_ready_i = 1'b0;
    chk("b_seen", 64'(got), 64'd1);
  endtask

  // AR, then collect beats with r_ready following rpat; stalled beats must not change.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [15:0] rpat);
    int          beat, cyc;
    bit          hs, stalled;
    logic [63:0] held;
    axi_ar_valid_i = 1'b1; axi_ar_addr_i = addr; axi_ar_len_i = len;
    axi_ar_size_i = size; axi_ar_burst_i = burst; axi_ar_id_i = id;
    cyc = 0;
    while (axi_ar_valid_i && cyc < 64) begin
      @(negedge aclk);
      hs = axi_ar_ready_o;
      @(posedge aclk); #1;
      cyc++;
      if (hs) axi_ar_valid_i = 1'b0;
    end
    chk("ar_handshake_done", 64'(cyc < 64), 64'd1);
    axi_ar_valid_i = 1'b0;
    beat = 0; cyc = 0; rlat = 0; stalled = 1'b0; held = '0;
    while (beat <= int'(len) && cyc < 128) begin
      axi_r_ready_i = rpat[cyc % 16];
      @(negedge aclk);
      cyc++;
      if (axi_r_valid_o) begin
        if (rlat == 0) rlat = cyc;
        if (stalled) chk($sformatf("r_hold_b%0d", beat), axi_r_data_o, held);
        if (axi_r_ready_i) begin
          rd[beat] = axi_r_data_o; rr[beat] = axi_r_resp_o; rl[beat] = axi_r_last_o;
          rid_got = axi_r_id_o; beat++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = axi_r_data_o;
        end
      end
      @(posedge aclk); #1;
    end
    axi_r_ready_i = 1'b0;
    chk("r_burst_done", 64'(cyc < 128), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    areset_n = 1'b1;
    axi_aw_valid_i = 0; axi_aw_addr_i = 0; axi_aw_id_i = 0; axi_aw_len_i = 0;
    axi_aw_size_i = 0; axi_aw_burst_i = 0;
    axi_w_valid_i = 0; axi_w_data_i = 0; axi_w_strb_i = 0; axi_w_last_i = 0; axi_b_ready_i = 0;
    axi_ar_valid_i = 0; axi_ar_addr_i = 0; axi_ar_id_i = 0; axi_ar_len_i = 0;
    axi_ar_size_i = 0; axi_ar_burst_i = 0; axi_r_ready_i = 0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 8'hFF; end

    // Reset: everything quiet while the (active-high) reset is held.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_aw_ready", 64'(axi_aw_ready_o), 64'd0);
    chk("rst_ar_ready", 64'(axi_ar_ready_o), 64'd0);
    chk("rst_b_valid",  64'(axi_b_valid_o),  64'd0);
    chk("rst_r_valid",  64'(axi_r_valid_o),  64'd0);
    chk("rst_r_data",   axi_r_data_o,        64'd0);
    @(posedge aclk); #1; areset_n = 1'b0;
    @(negedge aclk);
    chk("idle_aw_ready", 64'(axi_aw_ready_o), 64'd1);
    chk("idle_ar_ready", 64'(axi_ar_ready_o), 64'd1);
    chk("idle_w_ready",  64'(axi_w_ready_o),  64'd0);
    @(posedge aclk); #1;

    // 1: single full-word write then read back.
    wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
    axi_write(32'h8000_0008, 8'd0, 3'd3, 2'b01, 4'h1);
    chk("t1_b_resp", 64'(bresp_got), 64'd0);
    chk("t1_b_id",   64'(bid_got),   64'd1);
    chk("t1_b_lat",  64'(bwait),     64'd1);
    axi_read(32'h8000_0008, 8'd0, 3'd3, 2'b01, 4'h2, 16'hFFFF);
    chk("t1_r_data", rd[0], 64'h1122_3344_5566_7788);
    chk("t1_r_last", 64'(rl[0]), 64'd1);
    chk("t1_r_resp", 64'(rr[0]), 64'd0);
    chk("t1_r_id",   64'(rid_got), 64'd2);
    chk("t1_r_lat",  64'(rlat), 64'd1);

    // 2: byte write into lane 3 of a cleared word.
    wd[0] = 64'd0; ws[0] = 8'hFF;
    axi_write(32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h0);
    wd[0] = 64'hAB << 24; ws[0] = 8'h08;
    axi_write(32'h8000_0003, 8'd0, 3'd0, 2'b01, 4'h0);
    chk("t2_b_resp", 64'(bresp_got), 64'd0);
    axi_read(32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h0, 16'hFFFF);
    chk("t2_r_data", rd[0], 64'h0000_0000_AB00_0000);

    // 3: INCR burst of 4, read back with r_ready toggling.
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    axi_write(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'h3);
    chk("t3_b_resp", 64'(bresp_got), 64'd0);
    chk("t3_b_id",   64'(bid_got),   64'd3);
    axi_read(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'h4, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_d%0d", i), rd[i], 64'(i + 1));
      chk($sformatf("t3_last%0d", i), 64'(rl[i]), 64'(i == 3));
    end

    // 4: out-of-range below base and one word past the end.
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
    axi_write(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'h6);
    chk("t4_lo_b_resp", 64'(bresp_got), 64'd2);
    axi_write(32'h8000_8000, 8'd0, 3'd3, 2'b01, 4'h6);
    chk("t4_hi_b_resp", 64'(bresp_got), 64'd2);
    axi_read(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'h6, 16'hFFFF);
    chk("t4_lo_r_data", rd[0], 64'd0);
    chk("t4_lo_r_resp", 64'(rr[0]), 64'd2);
    axi_read(32'h8000_8000, 8'd0, 3'd3, 2'b01, 4'h6, 16'hFFFF);
    chk("t4_hi_r_data", rd[0], 64'd0);
    chk("t4_hi_r_resp", 64'(rr[0]), 64'd2);
    axi_read(32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h6, 16'hFFFF);
    chk("t4_word0_kept", rd[0], 64'h0000_0000_AB00_0000);

    // 5: read and write bursts over the same words in the same cycles; B held off.
    wd[0] = 64'hA0; wd[1] = 64'hA1; ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(32'h8000_0200, 8'd1, 3'd3, 2'b01, 4'h1);
    axi_ar_valid_i = 1'b1; axi_ar_addr_i = 32'h8000_0200; axi_ar_len_i = 8'd1;
    axi_ar_size_i = 3'd3; axi_ar_burst_i = 2'b01; axi_ar_id_i = 4'h9; axi_r_ready_i = 1'b1;
    @(negedge aclk);
    chk("t5_ar_ready", 64'(axi_ar_ready_o), 64'd1);
    @(posedge aclk); #1;
    axi_ar_valid_i = 1'b0;
    axi_aw_valid_i = 1'b1; axi_aw_addr_i = 32'h8000_0200; axi_aw_len_i = 8'd1;
    axi_aw_size_i = 3'd3; axi_aw_burst_i = 2'b01; axi_aw_id_i = 4'h5;
    axi_w_valid_i = 1'b1; axi_w_data_i = 64'hB0; axi_w_strb_i = 8'hFF; axi_w_last_i = 1'b0;
    @(negedge aclk);
    chk("t5_aw_w_ready", 64'(axi_aw_ready_o & axi_w_ready_o), 64'd1);
    chk("t5_r0_valid", 64'(axi_r_valid_o), 64'd1);
    chk("t5_r0_prewrite", axi_r_data_o, 64'hA0);
    chk("t5_r_id", 64'(axi_r_id_o), 64'd9);
    @(posedge aclk); #1;
    axi_aw_valid_i = 1'b0; axi_w_data_i = 64'hB1; axi_w_last_i = 1'b1;
    @(negedge aclk);
    chk("t5_w1_ready", 64'(axi_w_ready_o), 64'd1);
    chk("t5_r1_prewrite", axi_r_data_o, 64'hA1);
    chk("t5_r1_last", 64'(axi_r_last_o), 64'd1);
    @(posedge aclk); #1;
    axi_w_valid_i = 1'b0; axi_w_last_i = 1'b0; axi_r_ready_i = 1'b0; axi_b_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk($sformatf("t5_b_held%0d", i), 64'(axi_b_valid_o), 64'd1);
      @(posedge aclk); #1;
    end
    axi_b_ready_i = 1'b1;
    @(negedge aclk);
    chk("t5_b_id", 64'(axi_b_id_o), 64'd5);
    chk("t5_b_resp", 64'(axi_b_resp_o), 64'd0);
    @(posedge aclk); #1; axi_b_ready_i = 1'b0;
    @(negedge aclk);
    chk("t5_b_done", 64'(axi_b_valid_o), 64'd0);
    @(posedge aclk); #1;
    axi_read(32'h8000_0200, 8'd1, 3'd3, 2'b01, 4'h2, 16'hFFFF);
    chk("t5_new0", rd[0], 64'hB0);
    chk("t5_new1", rd[1], 64'hB1);

    // FIXED burst: both beats land on the same word, the last one wins.
    wd[0] = 64'h5; wd[1] = 64'h6;
    axi_write(32'h8000_0300, 8'd1, 3'd3, 2'b00, 4'h7);
    chk("fx_b_resp", 64'(bresp_got), 64'd0);
    axi_read(32'h8000_0300, 8'd0, 3'd3, 2'b01, 4'h7, 16'hFFFF);
    chk("fx_r_data", rd[0], 64'h6);

    // 6: reset while beat 2 of 4 is on the bus.
    axi_ar_valid_i = 1'b1; axi_ar_addr_i = 32'h8000_0100; axi_ar_len_i = 8'd3;
    axi_ar_size_i = 3'd3; axi_ar_burst_i = 2'b01; axi_ar_id_i = 4'h3;
    @(posedge aclk); #1;
    axi_ar_valid_i = 1'b0; axi_r_ready_i = 1'b1;
    @(negedge aclk);
    chk("t6_beat1", axi_r_data_o, 64'd1);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("t6_beat2", axi_r_data_o, 64'd2);
    @(posedge aclk); #1; areset_n = 1'b1; axi_r_ready_i = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("t6_r_valid_rst", 64'(axi_r_valid_o), 64'd0);
    @(posedge aclk); #1; areset_n = 1'b0;
    @(negedge aclk);
    chk("t6_ar_ready", 64'(axi_ar_ready_o), 64'd1);
    chk("t6_r_valid",  64'(axi_r_valid_o),  64'd0);
    @(posedge aclk); #1;
    axi_read(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'h3, 16'hFFFF);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_intact%0d", i), rd[i], 64'(i + 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
